// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage.
// - Opcode constants for the supported RV32I subset.
// - Immediate format enum and a helper mapping opcode to format.
// - Hazard FSM state enum.
package decode_stage_pkg;

  localparam logic [6:0] OpRr   = 7'b0110011;
  localparam logic [6:0] OpIr   = 7'b0010011;
  localparam logic [6:0] OpLr   = 7'b0000011;
  localparam logic [6:0] OpSr   = 7'b0100011;
  localparam logic [6:0] OpB    = 7'b1100011;
  localparam logic [6:0] OpJalr = 7'b1100111;
  localparam logic [6:0] OpLui  = 7'b0110111;
  localparam logic [6:0] OpJal  = 7'b1101111;

  typedef enum logic [2:0] {
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ,
    ImmNone
  } imm_fmt_e;

  typedef enum logic [0:0] {
    StRun,
    StStall
  } haz_state_e;

  // RR and unknown opcodes carry no immediate.
  function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OpIr, OpLr, OpJalr: fmt = ImmI;
      OpSr:               fmt = ImmS;
      OpB:                fmt = ImmB;
      OpLui:              fmt = ImmU;
      OpJal:              fmt = ImmJ;
      default:            fmt = ImmNone;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder.
// Inputs : instruction, pc.
// Outputs: register fields, sign-extended immediate, control flags (we, ie, op, branch,
//          mem_read, mem_write, illegal), link address and source-use flags for hazard
//          detection (use_r1, use_r2).
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE     = 32,
  parameter int unsigned REG_ADDRESS_SIZE = 5
) (
  input  logic [ADDRESS_SIZE-1:0]     instruction,
  input  logic [ADDRESS_SIZE-1:0]     pc,
  output logic [REG_ADDRESS_SIZE-1:0] addr_r1,
  output logic [REG_ADDRESS_SIZE-1:0] addr_r2,
  output logic [REG_ADDRESS_SIZE-1:0] addr_rd,
  output logic [ADDRESS_SIZE-1:0]     immediate,
  output logic                        we,
  output logic                        ie,
  output logic                        op,
  output logic                        branch,
  output logic [ADDRESS_SIZE-1:0]     link,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic                        illegal,
  output logic                        use_r1,
  output logic                        use_r2
);

  logic [6:0]        opcode;
  logic [31:0]       instr32;
  imm_fmt_e          fmt;
  logic signed [31:0] imm32;
  logic              link_en;

  assign instr32 = instruction[31:0];
  assign opcode  = instr32[6:0];
  assign fmt     = imm_format(opcode);

  assign addr_r1 = REG_ADDRESS_SIZE'(instr32[19:15]);
  assign addr_r2 = REG_ADDRESS_SIZE'(instr32[24:20]);
  assign addr_rd = REG_ADDRESS_SIZE'(instr32[11:7]);

  always_comb begin
    imm32 = '0;
    case (fmt)
      ImmI: imm32 = {{20{instr32[31]}}, instr32[31:20]};
      ImmS: imm32 = {{20{instr32[31]}}, instr32[31:25], instr32[11:7]};
      ImmB: imm32 = {{19{instr32[31]}}, instr32[31], instr32[7], instr32[30:25],
                     instr32[11:8], 1'b0};
      ImmU: imm32 = {instr32[31:12], 12'b0};
      ImmJ: imm32 = {{11{instr32[31]}}, instr32[31], instr32[19:12], instr32[20],
                     instr32[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign immediate = ADDRESS_SIZE'(imm32);

  always_comb begin
    we        = 1'b0;
    ie        = 1'b0;
    op        = 1'b0;
    branch    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    use_r1    = 1'b0;
    use_r2    = 1'b0;
    link_en   = 1'b0;
    case (opcode)
      OpRr: begin
        we     = 1'b1;
        op     = instr32[30];
        use_r1 = 1'b1;
        use_r2 = 1'b1;
      end
      OpIr: begin
        we     = 1'b1;
        ie     = 1'b1;
        use_r1 = 1'b1;
      end
      OpLr: begin
        we       = 1'b1;
        ie       = 1'b1;
        mem_read = 1'b1;
        use_r1   = 1'b1;
      end
      OpSr: begin
        ie        = 1'b1;
        mem_write = 1'b1;
        use_r1    = 1'b1;
        use_r2    = 1'b1;
      end
      OpB: begin
        op     = 1'b1;
        branch = 1'b1;
        use_r1 = 1'b1;
        use_r2 = 1'b1;
      end
      OpJalr: begin
        we      = 1'b1;
        ie      = 1'b1;
        branch  = 1'b1;
        link_en = 1'b1;
        use_r1  = 1'b1;
      end
      OpLui: begin
        we = 1'b1;
        ie = 1'b1;
      end
      OpJal: begin
        we      = 1'b1;
        ie      = 1'b1;
        branch  = 1'b1;
        link_en = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Wraps modulo 2^ADDRESS_SIZE.
  assign link = link_en ? (pc + ADDRESS_SIZE'(4)) : '0;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   F_valid/F_ready       - fetch handshake; F_instruction, F_pc are the offered instruction
//   D_flush               - drop the held instruction and any pending stall
//   X_ready               - execute consumes the D outputs this cycle
//   D_*                   - registered decode results, meaningful while D_valid=1
// A load in D blocks dependent fetches; after it leaves, a STALL state keeps blocking
// instructions that read its rd for LOAD_USE_BUBBLES cycles.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE     = 32,
  parameter int unsigned REG_ADDRESS_SIZE = 5,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        F_valid,
  output logic                        F_ready,
  input  logic [ADDRESS_SIZE-1:0]     F_instruction,
  input  logic [ADDRESS_SIZE-1:0]     F_pc,
  input  logic                        D_flush,
  input  logic                        X_ready,
  output logic                        D_valid,
  output logic [ADDRESS_SIZE-1:0]     D_pc,
  output logic [REG_ADDRESS_SIZE-1:0] D_addr_r1,
  output logic [REG_ADDRESS_SIZE-1:0] D_addr_r2,
  output logic [REG_ADDRESS_SIZE-1:0] D_addr_rd,
  output logic [ADDRESS_SIZE-1:0]     D_immediate,
  output logic                        D_We,
  output logic                        D_Ie,
  output logic                        D_op,
  output logic                        D_branch,
  output logic [ADDRESS_SIZE-1:0]     D_link,
  output logic                        D_mem_read,
  output logic                        D_mem_write,
  output logic                        D_illegal
);

  logic [REG_ADDRESS_SIZE-1:0] dec_r1, dec_r2, dec_rd;
  logic [ADDRESS_SIZE-1:0]     dec_imm, dec_link;
  logic dec_we, dec_ie, dec_op, dec_branch, dec_mem_read, dec_mem_write, dec_illegal;
  logic dec_use_r1, dec_use_r2;

  decode_comb #(
    .ADDRESS_SIZE     (ADDRESS_SIZE),
    .REG_ADDRESS_SIZE (REG_ADDRESS_SIZE)
  ) u_decode_comb (
    .instruction (F_instruction),
    .pc          (F_pc),
    .addr_r1     (dec_r1),
    .addr_r2     (dec_r2),
    .addr_rd     (dec_rd),
    .immediate   (dec_imm),
    .we          (dec_we),
    .ie          (dec_ie),
    .op          (dec_op),
    .branch      (dec_branch),
    .link        (dec_link),
    .mem_read    (dec_mem_read),
    .mem_write   (dec_mem_write),
    .illegal     (dec_illegal),
    .use_r1      (dec_use_r1),
    .use_r2      (dec_use_r2)
  );

  haz_state_e                  state_q, state_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic [REG_ADDRESS_SIZE-1:0] haz_rd_q, haz_rd_d;

  logic load_in_d, load_leaves, dep_on_d, dep_on_haz, hazard, transfer;

  assign load_in_d   = D_valid && D_mem_read && (D_addr_rd != '0);
  assign load_leaves = load_in_d && X_ready;

  // Does the offered instruction read the given register? x0 never counts.
  assign dep_on_d   = (D_addr_rd != '0) &&
                      ((dec_use_r1 && (dec_r1 == D_addr_rd)) ||
                       (dec_use_r2 && (dec_r2 == D_addr_rd)));
  assign dep_on_haz = (haz_rd_q != '0) &&
                      ((dec_use_r1 && (dec_r1 == haz_rd_q)) ||
                       (dec_use_r2 && (dec_r2 == haz_rd_q)));

  // A load currently in D is checked in both states, so a newer load accepted during
  // STALL still protects its own consumer.
  always_comb begin
    hazard = load_in_d && dep_on_d;
    if (state_q == StStall) begin
      hazard = hazard || dep_on_haz;
    end
  end

  assign F_ready  = !reset && !D_flush && (!D_valid || X_ready) && !hazard;
  assign transfer = F_valid && F_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    haz_rd_d = haz_rd_q;
    if (D_flush) begin
      state_d = StRun;
      cnt_d   = 3'd0;
    end else if (load_leaves) begin
      // Newest load wins, also when already stalling.
      state_d  = StStall;
      cnt_d    = 3'(LOAD_USE_BUBBLES);
      haz_rd_d = D_addr_rd;
    end else if (state_q == StStall) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q <= 3'd1) begin
        state_d = StRun;
        cnt_d   = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      cnt_q    <= 3'd0;
      haz_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      haz_rd_q <= haz_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      D_valid     <= 1'b0;
      D_pc        <= '0;
      D_addr_r1   <= '0;
      D_addr_r2   <= '0;
      D_addr_rd   <= '0;
      D_immediate <= '0;
      D_We        <= 1'b0;
      D_Ie        <= 1'b0;
      D_op        <= 1'b0;
      D_branch    <= 1'b0;
      D_link      <= '0;
      D_mem_read  <= 1'b0;
      D_mem_write <= 1'b0;
      D_illegal   <= 1'b0;
    end else if (D_flush) begin
      D_valid <= 1'b0;
    end else if (transfer) begin
      D_valid     <= 1'b1;
      D_pc        <= F_pc;
      D_addr_r1   <= dec_r1;
      D_addr_r2   <= dec_r2;
      D_addr_rd   <= dec_rd;
      D_immediate <= dec_imm;
      D_We        <= dec_we;
      D_Ie        <= dec_ie;
      D_op        <= dec_op;
      D_branch    <= dec_branch;
      D_link      <= dec_link;
      D_mem_read  <= dec_mem_read;
      D_mem_write <= dec_mem_write;
      D_illegal   <= dec_illegal;
    end else if (D_valid && X_ready) begin
      D_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        F_valid;
  logic        F_ready;
  logic [31:0] F_instruction;
  logic [31:0] F_pc;
  logic        D_flush;
  logic        X_ready;
  logic        D_valid;
  logic [31:0] D_pc;
  logic [4:0]  D_addr_r1, D_addr_r2, D_addr_rd;
  logic [31:0] D_immediate;
  logic        D_We, D_Ie, D_op, D_branch;
  logic [31:0] D_link;
  logic        D_mem_read, D_mem_write, D_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage #(
    .ADDRESS_SIZE     (32),
    .REG_ADDRESS_SIZE (5),
    .LOAD_USE_BUBBLES (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .F_valid       (F_valid),
    .F_ready       (F_ready),
    .F_instruction (F_instruction),
    .F_pc          (F_pc),
    .D_flush       (D_flush),
    .X_ready       (X_ready),
    .D_valid       (D_valid),
    .D_pc          (D_pc),
    .D_addr_r1     (D_addr_r1),
    .D_addr_r2     (D_addr_r2),
    .D_addr_rd     (D_addr_rd),
    .D_immediate   (D_immediate),
    .D_We          (D_We),
    .D_Ie          (D_Ie),
    .D_op          (D_op),
    .D_branch      (D_branch),
    .D_link        (D_link),
    .D_mem_read    (D_mem_read),
    .D_mem_write   (D_mem_write),
    .D_illegal     (D_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctl = {we, ie, op, branch, mem_read, mem_write, illegal}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] link;
    logic [6:0]  ctl;
  } vec_t;

  localparam logic [31:0] AddiM1 = 32'hFFF00093;  // addi x1,x0,-1
  localparam logic [31:0] LwX5   = 32'h00012283;  // lw x5,0(x2)
  localparam logic [31:0] AddDep = 32'h00328333;  // add x6,x5,x3
  localparam logic [31:0] AddInd = 32'h00838333;  // add x6,x7,x8
  localparam logic [31:0] LuiX2  = 32'h12345137;  // lui x2,0x12345

  vec_t vecs [8] = '{
    '{AddiM1,       32'h100,      32'hFFFFFFFF, 32'h0,   7'b1100000},
    '{32'h008000EF, 32'h200,      32'h8,        32'h204, 7'b1101000},  // jal x1,+8
    '{32'h00008067, 32'hFFFFFFFC, 32'h0,        32'h0,   7'b1101000},  // jalr x0,0(x1)
    '{32'hFE312E23, 32'h300,      32'hFFFFFFFC, 32'h0,   7'b0100010},  // sw x3,-4(x2)
    '{32'hFE208CE3, 32'h304,      32'hFFFFFFF8, 32'h0,   7'b0011000},  // beq x1,x2,-8
    '{LuiX2,        32'h308,      32'h12345000, 32'h0,   7'b1100000},
    '{32'h402081B3, 32'h30C,      32'h0,        32'h0,   7'b1010000},  // sub x3,x1,x2
    '{32'h0000007F, 32'h310,      32'h0,        32'h0,   7'b0000001}   // illegal
  };

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    F_valid       = 1'b1;
    F_instruction = instr;
    F_pc          = pc;
    #1;
  endtask

  task automatic idle(input int n);
    F_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] instr;
    reset = 1'b1; F_valid = 1'b0; F_instruction = '0; F_pc = '0;
    D_flush = 1'b0; X_ready = 1'b1;
    tick(); tick();
    offer(AddiM1, 32'h100);
    check("reset_f_ready", {31'b0, F_ready}, 32'h0);
    check("reset_d_valid", {31'b0, D_valid}, 32'h0);
    check("reset_d_imm", D_immediate, 32'h0);
    check("reset_d_pc", D_pc, 32'h0);
    check("reset_d_we", {31'b0, D_We}, 32'h0);
    tick();
    reset = 1'b0;
    F_valid = 1'b0;
    tick();

    // Decode table, back-to-back with X_ready=1.
    for (int i = 0; i < 8; i++) begin
      offer(vecs[i].instr, vecs[i].pc);
      check($sformatf("v%0d_f_ready", i), {31'b0, F_ready}, 32'h1);
      tick();
      instr = vecs[i].instr;
      check($sformatf("v%0d_valid", i), {31'b0, D_valid}, 32'h1);
      check($sformatf("v%0d_pc", i), D_pc, vecs[i].pc);
      check($sformatf("v%0d_imm", i), D_immediate, vecs[i].imm);
      check($sformatf("v%0d_link", i), D_link, vecs[i].link);
      check($sformatf("v%0d_rd", i), {27'b0, D_addr_rd}, {27'b0, instr[11:7]});
      check($sformatf("v%0d_ctl", i),
            {25'b0, D_We, D_Ie, D_op, D_branch, D_mem_read, D_mem_write, D_illegal},
            {25'b0, vecs[i].ctl});
    end
    check("v0_r1_after", {27'b0, D_addr_r1}, 32'h0);  // illegal 0x7F has rs1 field 0
    idle(2);
    check("drain_valid", {31'b0, D_valid}, 32'h0);

    // Load-use: lw x5 then dependent add.
    offer(LwX5, 32'h400);
    check("lu_lw_accept", {31'b0, F_ready}, 32'h1);
    tick();
    check("lu_lw_memread", {31'b0, D_mem_read}, 32'h1);
    offer(AddDep, 32'h404);
    check("lu_c0_block", {31'b0, F_ready}, 32'h0);
    tick();
    check("lu_c1_valid", {31'b0, D_valid}, 32'h0);
    check("lu_c1_block", {31'b0, F_ready}, 32'h0);
    tick();
    check("lu_c2_accept", {31'b0, F_ready}, 32'h1);
    tick();
    check("lu_add_valid", {31'b0, D_valid}, 32'h1);
    check("lu_add_rd", {27'b0, D_addr_rd}, 32'h6);
    check("lu_add_pc", D_pc, 32'h404);
    idle(3);

    // Independent instruction follows the load without a bubble.
    offer(LwX5, 32'h500);
    tick();
    offer(AddInd, 32'h504);
    check("ind_accept", {31'b0, F_ready}, 32'h1);
    tick();
    check("ind_valid", {31'b0, D_valid}, 32'h1);
    check("ind_pc", D_pc, 32'h504);
    idle(3);

    // Second load while stalling reloads the stall.
    offer(LwX5, 32'h600);
    tick();
    offer(LwX5, 32'h604);
    check("rl_lw2_accept", {31'b0, F_ready}, 32'h1);
    tick();
    offer(AddDep, 32'h608);
    check("rl_c1_block", {31'b0, F_ready}, 32'h0);
    tick();
    check("rl_c2_block", {31'b0, F_ready}, 32'h0);
    tick();
    check("rl_c3_accept", {31'b0, F_ready}, 32'h1);
    tick();
    check("rl_add_pc", D_pc, 32'h608);
    idle(3);

    // Hold with X_ready=0, then flush.
    X_ready = 1'b0;
    offer(AddiM1, 32'h700);
    tick();
    for (int i = 0; i < 3; i++) begin
      offer(LuiX2, 32'h704);
      check($sformatf("hold%0d_f_ready", i), {31'b0, F_ready}, 32'h0);
      check($sformatf("hold%0d_pc", i), D_pc, 32'h700);
      check($sformatf("hold%0d_imm", i), D_immediate, 32'hFFFFFFFF);
      tick();
    end
    D_flush = 1'b1;
    #1;
    check("flush_f_ready", {31'b0, F_ready}, 32'h0);
    tick();
    D_flush = 1'b0;
    F_valid = 1'b0;
    #1;
    check("flush_valid", {31'b0, D_valid}, 32'h0);
    offer(AddDep, 32'h708);
    check("flush_run_accept", {31'b0, F_ready}, 32'h1);
    X_ready = 1'b1;
    idle(3);

    // Reset in the middle of a (reloaded) stall.
    offer(LwX5, 32'h800);
    tick();
    offer(LwX5, 32'h804);
    tick();
    offer(AddDep, 32'h808);
    reset = 1'b1;
    #1;
    check("rst_stall_f_ready", {31'b0, F_ready}, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_stall_valid", {31'b0, D_valid}, 32'h0);
    check("rst_stall_accept", {31'b0, F_ready}, 32'h1);
    tick();
    check("rst_add_valid", {31'b0, D_valid}, 32'h1);
    check("rst_add_pc", D_pc, 32'h808);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
